// File: rtl/wb_decode_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wb_decode_pkg - shared widths and FSM states for the Wishbone decoder      |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package wb_decode_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 32;
  localparam int WB_SEL_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage : wb_decode_pkg
`default_nettype wire

// File: rtl/wb_addr_match.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wb_addr_match - combinational priority range decoder, lowest index wins    |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module wb_addr_match
  import wb_decode_pkg::*;
#(
  parameter int C_NUM_SLAVES = 4,
  parameter int IDX_W        = 2
) (
  input  logic [WB_ADDR_W-1:0]              adr_i,
  input  logic [C_NUM_SLAVES*WB_ADDR_W-1:0] bases_i,
  input  logic [C_NUM_SLAVES*WB_ADDR_W-1:0] highs_i,
  output logic                              hit_o,
  output logic [IDX_W-1:0]                  idx_o
);

  logic [C_NUM_SLAVES-1:0] in_range;

  for (genvar g = 0; g < C_NUM_SLAVES; g++) begin : g_range
    assign in_range[g] = (adr_i >= bases_i[g*WB_ADDR_W +: WB_ADDR_W]) &&
                         (adr_i <= highs_i[g*WB_ADDR_W +: WB_ADDR_W]);
  end

  // Scan downwards so the lowest matching index is the last one written.
  always_comb begin
    hit_o = |in_range;
    idx_o = '0;
    for (int i = C_NUM_SLAVES - 1; i >= 0; i--) begin
      if (in_range[i]) begin
        idx_o = IDX_W'(i);
      end
    end
  end

endmodule : wb_addr_match
`default_nettype wire

// File: rtl/wb_slave_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wb_slave_decoder - registered 1-to-N Wishbone decoder with err on timeout  |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module wb_slave_decoder
  import wb_decode_pkg::*;
#(
  parameter int C_NUM_SLAVES = 4,
  parameter logic [C_NUM_SLAVES*WB_ADDR_W-1:0] C_SLAVE_BASES = {C_NUM_SLAVES{32'h0}},
  parameter logic [C_NUM_SLAVES*WB_ADDR_W-1:0] C_SLAVE_HIGHS = {C_NUM_SLAVES{32'hF}},
  parameter int C_TIMEOUT = 255
) (
  input  logic                              wb_clk_i,
  input  logic                              wb_rst_i,
  input  logic                              wbm_cyc_i,
  input  logic                              wbm_stb_i,
  input  logic                              wbm_we_i,
  input  logic [WB_SEL_W-1:0]               wbm_sel_i,
  input  logic [WB_ADDR_W-1:0]              wbm_adr_i,
  input  logic [WB_DATA_W-1:0]              wbm_dat_i,
  output logic [WB_DATA_W-1:0]              wbm_dat_o,
  output logic                              wbm_ack_o,
  output logic                              wbm_err_o,
  output logic [C_NUM_SLAVES-1:0]           wbs_cyc_o,
  output logic [C_NUM_SLAVES-1:0]           wbs_stb_o,
  output logic                              wbs_we_o,
  output logic [WB_SEL_W-1:0]               wbs_sel_o,
  output logic [WB_ADDR_W-1:0]              wbs_adr_o,
  output logic [WB_DATA_W-1:0]              wbs_dat_o,
  input  logic [C_NUM_SLAVES*WB_DATA_W-1:0] wbs_dat_i,
  input  logic [C_NUM_SLAVES-1:0]           wbs_ack_i,
  input  logic [C_NUM_SLAVES-1:0]           wbs_err_i
);

  localparam int IDX_W = (C_NUM_SLAVES > 1) ? $clog2(C_NUM_SLAVES) : 1;
  localparam int CNT_W = $clog2(C_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(C_TIMEOUT - 1);

  state_t                  state_q, state_d;
  logic [C_NUM_SLAVES-1:0] cyc_q, cyc_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    we_q, we_d;
  logic [WB_SEL_W-1:0]     sel_q, sel_d;
  logic [WB_ADDR_W-1:0]    adr_q, adr_d;
  logic [WB_DATA_W-1:0]    wdat_q, wdat_d;
  logic [WB_DATA_W-1:0]    rdat_q, rdat_d;
  logic                    ack_q, ack_d;
  logic                    err_q, err_d;

  logic                    match_hit;
  logic [IDX_W-1:0]        match_idx;
  logic                    sel_ack, sel_err;
  logic [WB_DATA_W-1:0]    sel_dat;

  wb_addr_match #(
    .C_NUM_SLAVES (C_NUM_SLAVES),
    .IDX_W        (IDX_W)
  ) u_addr_match (
    .adr_i   (wbm_adr_i),
    .bases_i (C_SLAVE_BASES),
    .highs_i (C_SLAVE_HIGHS),
    .hit_o   (match_hit),
    .idx_o   (match_idx)
  );

  // Only the selected slave's response is visible; all others are ignored.
  assign sel_ack = wbs_ack_i[idx_q];
  assign sel_err = wbs_err_i[idx_q];
  assign sel_dat = wbs_dat_i[32'(idx_q)*WB_DATA_W +: WB_DATA_W];

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (wbm_cyc_i && wbm_stb_i) begin
          we_d   = wbm_we_i;
          sel_d  = wbm_sel_i;
          adr_d  = wbm_adr_i;
          wdat_d = wbm_dat_i;
          if (match_hit) begin
            idx_d   = match_idx;
            cyc_d   = C_NUM_SLAVES'(1) << match_idx;
            cnt_d   = '0;
            state_d = ACTIVE;
          end else begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      ACTIVE: begin
        if (!wbm_cyc_i) begin
          cyc_d   = '0;
          state_d = IDLE;
        end else if (sel_err) begin
          cyc_d   = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else if (sel_ack) begin
          if (!we_q) begin
            rdat_d = sel_dat;
          end
          cyc_d   = '0;
          ack_d   = 1'b1;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          cyc_d   = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // One dead cycle lets the master drop stb before the next decode.
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        cyc_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign wbm_dat_o = rdat_q;
  assign wbm_ack_o = ack_q;
  assign wbm_err_o = err_q;
  assign wbs_cyc_o = cyc_q;
  assign wbs_stb_o = cyc_q;
  assign wbs_we_o  = we_q;
  assign wbs_sel_o = sel_q;
  assign wbs_adr_o = adr_q;
  assign wbs_dat_o = wdat_q;

endmodule : wb_slave_decoder
`default_nettype wire

// File: tb/tb_wb_slave_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_wb_slave_decoder - bench for wb_slave_decoder, 4 slaves, timeout 8      |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_wb_slave_decoder;

  localparam int N   = 4;
  localparam int TMO = 8;
  localparam logic [N*32-1:0] BASES = {32'h340, 32'h300, 32'h100, 32'h000};
  localparam logic [N*32-1:0] HIGHS = {32'h3FF, 32'h37F, 32'h10F, 32'h0FF};

  logic          clk = 1'b0;
  logic          rst, cyc, stb, we;
  logic [3:0]    sel;
  logic [31:0]   adr, wdat;
  logic [31:0]   dat_o;
  logic          ack_o, err_o;
  logic [N-1:0]  scyc, sstb, sack, serr;
  logic          swe;
  logic [3:0]    ssel;
  logic [31:0]   sadr, sdato;
  logic [N*32-1:0] sdat;

  logic [31:0] rdat [N];
  logic [31:0] rb [N] = '{32'h000, 32'h100, 32'h300, 32'h340};
  logic [31:0] rh [N] = '{32'h0FF, 32'h10F, 32'h37F, 32'h3FF};
  int          mode [N];
  int          dly  [N];
  bit          rogue [N];
  int          scnt [N];
  int          total = 0;
  int          bad   = 0;

  assign sdat = {rdat[3], rdat[2], rdat[1], rdat[0]};

  always #5 clk = ~clk;

  wb_slave_decoder #(
    .C_NUM_SLAVES  (N),
    .C_SLAVE_BASES (BASES),
    .C_SLAVE_HIGHS (HIGHS),
    .C_TIMEOUT     (TMO)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbm_cyc_i (cyc),
    .wbm_stb_i (stb),
    .wbm_we_i  (we),
    .wbm_sel_i (sel),
    .wbm_adr_i (adr),
    .wbm_dat_i (wdat),
    .wbm_dat_o (dat_o),
    .wbm_ack_o (ack_o),
    .wbm_err_o (err_o),
    .wbs_cyc_o (scyc),
    .wbs_stb_o (sstb),
    .wbs_we_o  (swe),
    .wbs_sel_o (ssel),
    .wbs_adr_o (sadr),
    .wbs_dat_o (sdato),
    .wbs_dat_i (sdat),
    .wbs_ack_i (sack),
    .wbs_err_i (serr)
  );

  // Slave models: respond once stb has been seen on more than dly[i] samples.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      scnt[i] = sstb[i] ? scnt[i] + 1 : 0;
      sack[i] = (scnt[i] > dly[i]) && ((mode[i] & 1) != 0);
      serr[i] = (scnt[i] > dly[i]) && ((mode[i] & 2) != 0);
      if (rogue[i] && ((sstb & ~(N'(1) << i)) != '0)) sack[i] = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic set_all(input int m, input int d);
    for (int i = 0; i < N; i++) begin
      mode[i]  = m;
      dly[i]   = d;
      rogue[i] = 1'b0;
    end
  endtask

  // Presents one request, holds it until ack/err, then watches two more cycles.
  // Edges are numbered with the request-sampling edge as 0.
  task automatic run_txn(input logic [31:0] a, input bit w, input logic [31:0] wd,
                         output int ea, output int ee, output int na, output int ne,
                         output logic [3:0] so, output int sc);
    logic [3:0] s;
    int dk;
    s = 4'($urandom);
    ea = 0; ee = 0; na = 0; ne = 0; so = '0; sc = 0; dk = -1;
    adr = a; we = w; wdat = wd; sel = s; cyc = 1'b1; stb = 1'b1;
    for (int k = 0; k < 30; k++) begin
      step();
      if (k == 0) chk("latch", {sadr, sdato, swe, ssel}, {a, wd, w, s});
      chk("stb_eq_cyc", sstb, scyc);
      so |= sstb;
      if (sstb != '0) sc++;
      if (ack_o) begin na++; if (ea == 0) ea = k + 1; end
      if (err_o) begin ne++; if (ee == 0) ee = k + 1; end
      if ((ack_o || err_o) && dk < 0) begin
        dk = k; cyc = 1'b0; stb = 1'b0;
      end
      if (dk >= 0 && k >= dk + 2) break;
    end
    cyc = 1'b0; stb = 1'b0;
    chk("txn_terminated", (dk >= 0), 1'b1);
  endtask

  typedef struct {
    logic [31:0] a;  bit w;   logic [31:0] wd; int m; int d;
    logic [3:0]  xs; int xsc; int xa; int xe; logic [31:0] xd;
  } vec_t;

  vec_t tbl [13];

  initial begin
    int ea, ee, na, ne, sc, first, second, cnt, tgt, m, d, xsc, xa, xe;
    logic [3:0]  so, xs;
    logic [31:0] a, wd, exp_dat;
    bit w;

    tbl[0]  = '{32'h104, 1'b0, 32'h11, 1, 1, 4'b0010, 2, 3, 0, 32'hDEADBEEF};
    tbl[1]  = '{32'h200, 1'b1, 32'h22, 1, 1, 4'b0000, 0, 0, 1, 32'hDEADBEEF};
    tbl[2]  = '{32'h010, 1'b1, 32'h33, 1, 1, 4'b0001, 2, 3, 0, 32'hDEADBEEF};
    tbl[3]  = '{32'h360, 1'b0, 32'h44, 1, 2, 4'b0100, 3, 4, 0, 32'hC2C22222};
    tbl[4]  = '{32'h3A0, 1'b0, 32'h55, 1, 0, 4'b1000, 1, 2, 0, 32'hD3D33333};
    tbl[5]  = '{32'h0FF, 1'b0, 32'h66, 2, 1, 4'b0001, 2, 0, 3, 32'hD3D33333};
    tbl[6]  = '{32'h110, 1'b0, 32'h77, 1, 1, 4'b0000, 0, 0, 1, 32'hD3D33333};
    tbl[7]  = '{32'h100, 1'b0, 32'h88, 3, 1, 4'b0010, 2, 0, 3, 32'hD3D33333};
    tbl[8]  = '{32'h2FF, 1'b1, 32'h99, 1, 1, 4'b0000, 0, 0, 1, 32'hD3D33333};
    tbl[9]  = '{32'h37F, 1'b0, 32'hAA, 0, 0, 4'b0100, 8, 0, 9, 32'hD3D33333};
    tbl[10] = '{32'h000, 1'b0, 32'hBB, 1, 3, 4'b0001, 4, 5, 0, 32'hA0A00000};
    tbl[11] = '{32'h3FF, 1'b0, 32'hCC, 1, 1, 4'b1000, 2, 3, 0, 32'hD3D33333};
    tbl[12] = '{32'h340, 1'b0, 32'hDD, 1, 1, 4'b0100, 2, 3, 0, 32'hC2C22222};

    rdat[0] = 32'hA0A00000; rdat[1] = 32'hDEADBEEF;
    rdat[2] = 32'hC2C22222; rdat[3] = 32'hD3D33333;
    set_all(0, 0);
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; adr = '0; wdat = '0;
    repeat (3) step();
    chk("reset_outputs", {dat_o, ack_o, err_o, scyc, sstb, swe, ssel, sadr, sdato}, '0);
    rst = 1'b0;
    step();

    for (int v = 0; v < 13; v++) begin
      set_all(tbl[v].m, tbl[v].d);
      run_txn(tbl[v].a, tbl[v].w, tbl[v].wd, ea, ee, na, ne, so, sc);
      chk($sformatf("v%0d_stb", v), so, tbl[v].xs);
      chk($sformatf("v%0d_stb_cycles", v), sc, tbl[v].xsc);
      chk($sformatf("v%0d_ack_edge", v), ea, tbl[v].xa);
      chk($sformatf("v%0d_err_edge", v), ee, tbl[v].xe);
      chk($sformatf("v%0d_pulses", v), na + ne, 1);
      chk($sformatf("v%0d_dat", v), dat_o, tbl[v].xd);
    end

    // Slave3 acks while slave2 owns the bus; only slave2's own ack counts.
    set_all(1, 3);
    rogue[3] = 1'b1;
    run_txn(32'h320, 1'b0, 32'h0, ea, ee, na, ne, so, sc);
    chk("rogue_ack_edge", ea, 5);
    chk("rogue_err_cnt", ne, 0);
    chk("rogue_dat", dat_o, 32'hC2C22222);
    rogue[3] = 1'b0;

    // Master abort in the second ACTIVE cycle.
    set_all(0, 0);
    adr = 32'h104; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    step();
    step();
    chk("abort_stb_active", sstb, 4'b0010);
    cyc = 1'b0; stb = 1'b0;
    step();
    chk("abort_stb_dropped", sstb, 4'b0000);
    cnt = 0;
    repeat (3) begin
      step();
      cnt += int'(ack_o) + int'(err_o);
    end
    chk("abort_no_pulse", cnt, 0);
    set_all(1, 1);
    run_txn(32'h104, 1'b0, 32'h0, ea, ee, na, ne, so, sc);
    chk("post_abort_ack_edge", ea, 3);
    chk("post_abort_dat", dat_o, 32'hDEADBEEF);

    // Reset while a transfer is pending.
    set_all(0, 0);
    adr = 32'h000; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    step();
    step();
    chk("pre_reset_stb", sstb, 4'b0001);
    rst = 1'b1;
    step();
    chk("mid_reset_outputs", {dat_o, ack_o, err_o, scyc, sstb, swe, ssel, sadr, sdato}, '0);
    rst = 1'b0; cyc = 1'b0; stb = 1'b0;
    step();
    set_all(1, 1);
    run_txn(32'h104, 1'b0, 32'h0, ea, ee, na, ne, so, sc);
    chk("post_reset_ack_edge", ea, 3);

    // Back-to-back reads: next request presented as soon as the first ack is seen.
    set_all(1, 1);
    adr = 32'h000; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    first = 0; second = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (ack_o) begin
        if (first == 0) begin
          first = k + 1;
          chk("b2b_first_dat", dat_o, 32'hA0A00000);
          adr = 32'h104;
        end else begin
          second = k + 1;
          break;
        end
      end
    end
    cyc = 1'b0; stb = 1'b0;
    chk("b2b_first_edge", first, 3);
    chk("b2b_gap", second - first, 4);
    chk("b2b_second_dat", dat_o, 32'hDEADBEEF);
    step();
    step();

    // Randomized transfers against a range-lookup reference model.
    exp_dat = 32'hDEADBEEF;
    for (int t = 0; t < 40; t++) begin
      tgt = int'($urandom_range(0, 4));
      if (tgt == 4) begin
        a = ($urandom & 1) ? 32'h110 + $urandom_range(0, 32'h1EF)
                           : 32'h400 + $urandom_range(0, 32'hFFFF);
      end else begin
        a = rb[tgt] + $urandom_range(0, rh[tgt] - rb[tgt]);
      end
      w  = bit'($urandom & 1);
      wd = $urandom;
      m  = int'($urandom_range(0, 3));
      d  = int'($urandom_range(0, 3));
      set_all(m, d);
      for (int i = 0; i < N; i++) rdat[i] = $urandom;

      tgt = -1;
      for (int i = N - 1; i >= 0; i--) begin
        if (a >= rb[i] && a <= rh[i]) tgt = i;
      end
      xs = '0; xsc = 0; xa = 0; xe = 0;
      if (tgt < 0) begin
        xe = 1;
      end else if (m == 0) begin
        xs = 4'(1 << tgt); xsc = TMO; xe = TMO + 1;
      end else begin
        xs = 4'(1 << tgt); xsc = d + 1;
        if ((m & 2) != 0) begin
          xe = d + 2;
        end else begin
          xa = d + 2;
          if (!w) exp_dat = rdat[tgt];
        end
      end

      run_txn(a, w, wd, ea, ee, na, ne, so, sc);
      chk($sformatf("r%0d_stb", t), so, xs);
      chk($sformatf("r%0d_stb_cycles", t), sc, xsc);
      chk($sformatf("r%0d_ack_edge", t), ea, xa);
      chk($sformatf("r%0d_err_edge", t), ee, xe);
      chk($sformatf("r%0d_pulses", t), na + ne, 1);
      chk($sformatf("r%0d_dat", t), dat_o, exp_dat);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_wb_slave_decoder
`default_nettype wire
